// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART command parser.
// The debug struct gives checkers a stable view of both FSMs.
package uart_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_ESC = 8'h1B;

    localparam int         NUM_DIGITS_DEFAULT = 4;
    localparam logic [7:0] ACK_OK_DEFAULT     = 8'h4B;
    localparam logic [7:0] ACK_ERR_DEFAULT    = 8'h45;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        ERROR = 2'd2
    } parse_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_e;

    typedef struct packed {
        parse_state_e parse_state;
        tx_state_e    tx_state;
    } dbg_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational byte classifier: hex digit (with its value), line terminator, escape.
module ascii_hex_decode
    import uart_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_hex,
    output logic       is_term,
    output logic       is_esc,
    output logic [3:0] nibble
);

    always_comb begin
        is_hex  = 1'b0;
        nibble  = 4'h0;
        is_term = (byte_in == CHAR_CR) || (byte_in == CHAR_LF);
        is_esc  = (byte_in == CHAR_ESC);
        if (byte_in >= 8'h30 && byte_in <= 8'h39) begin
            is_hex = 1'b1;
            nibble = byte_in[3:0];
        end else if ((byte_in >= 8'h41 && byte_in <= 8'h46) ||
                     (byte_in >= 8'h61 && byte_in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15.
            is_hex = 1'b1;
            nibble = byte_in[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Line-oriented hex command parser: accumulates hex digits, commits on CR/LF
// to the display and answers each non-empty line with K or E over uart_tx.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int         NUM_DIGITS = NUM_DIGITS_DEFAULT,
    parameter logic [7:0] ACK_OK     = ACK_OK_DEFAULT,
    parameter logic [7:0] ACK_ERR    = ACK_ERR_DEFAULT,
    localparam int        W          = 4 * NUM_DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_d_val,
    input  logic         tx_done,
    output logic [W-1:0] disp_data,
    output logic         disp_upd,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    output logic         err,
    output logic         tx_ovf,
    output dbg_t         dbg
);

    localparam int CW = $clog2(NUM_DIGITS + 1);

    logic       is_hex, is_term, is_esc;
    logic [3:0] nibble;

    ascii_hex_decode u_decode (
        .byte_in (rx_data),
        .is_hex  (is_hex),
        .is_term (is_term),
        .is_esc  (is_esc),
        .nibble  (nibble)
    );

    parse_state_e  parse_state_q, parse_state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  disp_data_q, disp_data_d;
    logic          disp_upd_q, disp_upd_d;
    logic          err_q, err_d;
    logic          req_ok, req_err;

    tx_state_e     tx_state_q, tx_state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          tx_ovf_q, tx_ovf_d;

    always_comb begin
        parse_state_d = parse_state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        disp_data_d   = disp_data_q;
        disp_upd_d    = 1'b0;
        err_d         = 1'b0;
        req_ok        = 1'b0;
        req_err       = 1'b0;
        if (rx_d_val) begin
            case (parse_state_q)
                EMPTY: begin
                    if (is_hex) begin
                        acc_d         = W'(nibble);
                        cnt_d         = CW'(1);
                        parse_state_d = ACCUM;
                    end else if (!is_term && !is_esc) begin
                        parse_state_d = ERROR;
                    end
                end
                ACCUM: begin
                    if (is_hex && cnt_q != CW'(NUM_DIGITS)) begin
                        acc_d = (acc_q << 4) | W'(nibble);
                        cnt_d = cnt_q + CW'(1);
                    end else if (is_term) begin
                        disp_data_d   = acc_q;
                        disp_upd_d    = 1'b1;
                        req_ok        = 1'b1;
                        acc_d         = '0;
                        cnt_d         = '0;
                        parse_state_d = EMPTY;
                    end else if (is_esc) begin
                        acc_d         = '0;
                        cnt_d         = '0;
                        parse_state_d = EMPTY;
                    end else begin
                        // Overlong value or a non-hex byte poisons the rest of the line.
                        acc_d         = '0;
                        cnt_d         = '0;
                        parse_state_d = ERROR;
                    end
                end
                ERROR: begin
                    if (is_term) begin
                        err_d         = 1'b1;
                        req_err       = 1'b1;
                        parse_state_d = EMPTY;
                    end else if (is_esc) begin
                        parse_state_d = EMPTY;
                    end
                end
                default: parse_state_d = EMPTY;
            endcase
        end
    end

    // Handshake with uart_tx: tx_start is a one-cycle request; tx_data is held
    // until the matching tx_done strobe. There is no queue: a request made while
    // a byte is outstanding (including the tx_done cycle itself) is dropped and
    // recorded in the sticky tx_ovf.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tx_ovf_d   = tx_ovf_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (req_ok || req_err) begin
                    tx_data_d  = req_ok ? ACK_OK : ACK_ERR;
                    tx_start_d = 1'b1;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (req_ok || req_err) begin
                    tx_ovf_d = 1'b1;
                end
                if (tx_done) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parse_state_q <= EMPTY;
            acc_q         <= '0;
            cnt_q         <= '0;
            disp_data_q   <= '0;
            disp_upd_q    <= 1'b0;
            err_q         <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_data_q     <= 8'h00;
            tx_start_q    <= 1'b0;
            tx_ovf_q      <= 1'b0;
        end else begin
            parse_state_q <= parse_state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            disp_data_q   <= disp_data_d;
            disp_upd_q    <= disp_upd_d;
            err_q         <= err_d;
            tx_state_q    <= tx_state_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            tx_ovf_q      <= tx_ovf_d;
        end
    end

    assign disp_data       = disp_data_q;
    assign disp_upd        = disp_upd_q;
    assign err             = err_q;
    assign tx_data         = tx_data_q;
    assign tx_start        = tx_start_q;
    assign tx_ovf          = tx_ovf_q;
    assign dbg.parse_state = parse_state_q;
    assign dbg.tx_state    = tx_state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed line scenarios followed by random byte
// traffic, checked against a line-level reference model.
module tb_uart_cmd_parser;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_d_val = 1'b0;
    logic        tx_done = 1'b0;
    logic [15:0] disp_data;
    logic        disp_upd;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        err;
    logic        tx_ovf;
    dbg_t        dbg;

    uart_cmd_parser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_d_val  (rx_d_val),
        .tx_done   (tx_done),
        .disp_data (disp_data),
        .disp_upd  (disp_upd),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .err       (err),
        .tx_ovf    (tx_ovf),
        .dbg       (dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model: the current line is kept as raw bytes and judged as a whole
    // when a terminator arrives.
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  line_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] m_disp = 16'h0000;
    logic [7:0]  m_txd  = 8'h00;
    bit          m_busy = 1'b0;
    bit          m_ovf  = 1'b0;

    function automatic int hex_val(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - int'("0");
        if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
        if (b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
        return -1;
    endfunction

    task automatic model_reset();
        line_q.delete();
        exp_q.delete();
        m_disp = 16'h0000;
        m_txd  = 8'h00;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] b, input bit v, input bit done,
                              output bit e_upd, output bit e_err, output bit e_start);
        bit     req_ok, req_err, busy_before, ok;
        longint val;
        e_upd = 0; e_err = 0; e_start = 0; req_ok = 0; req_err = 0;
        if (v) begin
            if (b == 8'h1B) begin
                line_q.delete();
            end else if (b == 8'h0D || b == 8'h0A) begin
                if (line_q.size() > 0) begin
                    ok  = (line_q.size() <= 4);
                    val = 0;
                    foreach (line_q[i]) begin
                        if (hex_val(line_q[i]) < 0) ok = 0;
                        else val = val * 16 + hex_val(line_q[i]);
                    end
                    if (ok) begin
                        m_disp = 16'(val);
                        e_upd  = 1;
                        req_ok = 1;
                    end else begin
                        e_err   = 1;
                        req_err = 1;
                    end
                    line_q.delete();
                end
            end else begin
                line_q.push_back(b);
            end
        end
        busy_before = m_busy;
        if (req_ok || req_err) begin
            if (busy_before) begin
                m_ovf = 1;
            end else begin
                m_txd   = req_ok ? 8'h4B : 8'h45;
                e_start = 1;
                exp_q.push_back(m_txd);
            end
        end
        m_busy = busy_before ? !done : (req_ok || req_err);
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: one clock per call, outputs sampled 1 time unit after the edge.
    task automatic step(input logic [7:0] b, input bit v, input bit done);
        bit e_upd, e_err, e_start;
        rx_data  = b;
        rx_d_val = v;
        tx_done  = done;
        model_step(b, v, done, e_upd, e_err, e_start);
        @(posedge clk);
        #1;
        rx_d_val = 1'b0;
        tx_done  = 1'b0;
        check("disp_upd",  disp_upd,  e_upd);
        check("err",       err,       e_err);
        check("tx_start",  tx_start,  e_start);
        check("disp_data", disp_data, m_disp);
        check("tx_data",   tx_data,   m_txd);
        check("tx_ovf",    tx_ovf,    m_ovf);
        if (tx_start === 1'b1) begin
            check("tx_q_avail", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_disp_data"}, disp_data, 16'h0000);
        check({tag, "_disp_upd"},  disp_upd,  1'b0);
        check({tag, "_tx_data"},   tx_data,   8'h00);
        check({tag, "_tx_start"},  tx_start,  1'b0);
        check({tag, "_err"},       err,       1'b0);
        check({tag, "_tx_ovf"},    tx_ovf,    1'b0);
        check({tag, "_parse_st"},  dbg.parse_state, EMPTY);
        check({tag, "_tx_st"},     dbg.tx_state,    TX_IDLE);
    endtask

    initial begin
        logic [7:0] ch;
        int         r, d;

        // Reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst0");
        rst = 1'b0;
        step(8'h00, 1'b0, 1'b0);

        // 12Af CR commits 0x12AF and answers K
        send_str("12Af");
        step(8'h0D, 1'b1, 1'b0);
        check("t1_disp", disp_data, 16'h12AF);
        check("t1_upd",  disp_upd,  1'b1);
        check("t1_start", tx_start, 1'b1);
        check("t1_txd",  tx_data,   8'h4B);
        step(8'h00, 1'b0, 1'b1);

        // 7 CR LF: one K, LF silent
        send_str("7");
        step(8'h0D, 1'b1, 1'b0);
        check("t2_disp", disp_data, 16'h0007);
        check("t2_start", tx_start, 1'b1);
        step(8'h0A, 1'b1, 1'b1);
        check("t2_lf_start", tx_start, 1'b0);
        check("t2_lf_upd",   disp_upd, 1'b0);

        // Overlong and bad-character lines are rejected
        send_str("12345");
        step(8'h0D, 1'b1, 1'b0);
        check("t3_err",  err,       1'b1);
        check("t3_txd",  tx_data,   8'h45);
        check("t3_disp", disp_data, 16'h0007);
        step(8'h00, 1'b0, 1'b1);
        send_str("G");
        step(8'h0D, 1'b1, 1'b0);
        check("t3g_err",  err,       1'b1);
        check("t3g_disp", disp_data, 16'h0007);
        step(8'h00, 1'b0, 1'b1);

        // ESC abandons the line silently
        send_str("AB");
        step(8'h1B, 1'b1, 1'b0);
        step(8'h0D, 1'b1, 1'b0);
        check("t4_upd",   disp_upd, 1'b0);
        check("t4_start", tx_start, 1'b0);
        check("t4_err",   err,      1'b0);

        // Second response while busy is dropped; display still updates
        send_str("1");
        step(8'h0D, 1'b1, 1'b0);
        send_str("2");
        step(8'h0D, 1'b1, 1'b0);
        check("t5_disp",  disp_data, 16'h0002);
        check("t5_start", tx_start,  1'b0);
        check("t5_ovf",   tx_ovf,    1'b1);
        send_str("3");
        step(8'h0D, 1'b1, 1'b1);
        check("t5_coinc_start", tx_start, 1'b0);
        check("t5_coinc_disp",  disp_data, 16'h0003);
        send_str("4");
        step(8'h0D, 1'b1, 1'b0);
        check("t5_after_start", tx_start, 1'b1);
        check("t5_after_txd",   tx_data,  8'h4B);

        // Reset mid-line and mid-TX
        send_str("34");
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values("rst1");
        rst = 1'b0;
        send_str("5");
        step(8'h0D, 1'b1, 1'b0);
        check("t6_disp", disp_data, 16'h0005);
        check("t6_start", tx_start, 1'b1);
        step(8'h00, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 19);
            d = $urandom_range(0, 15);
            if (r <= 9 || r == 19) begin
                if (d < 10)                     ch = 8'(8'h30 + d);
                else if ($urandom_range(0, 1)) ch = 8'(8'h41 + d - 10);
                else                            ch = 8'(8'h61 + d - 10);
            end else if (r <= 14) ch = 8'h0D;
            else if (r == 15)     ch = 8'h0A;
            else if (r == 16)     ch = 8'h1B;
            else if (r == 17)     ch = "G";
            else                  ch = 8'($urandom_range(0, 255));
            step(ch, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0);
        end
        check("txq_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-stream command parser sitting directly downstream of `uart_rx`: consumes each received byte and accumulates ASCII hex digits into a display value. On a line terminator it commits the value to the 4-digit seven-segment display path. It also issues a one-byte acknowledgement (`K`/`E`) to `uart_tx` through a start/done handshake. It replaces the raw-byte loopback with a line-oriented command interface.

## Interface
- `NUM_DIGITS`, 4, hex digits per value; value width W = 4*NUM_DIGITS
- `ACK_OK`, 8'h4B, response byte for an accepted line (`K`)
- `ACK_ERR`, 8'h45, response byte for a rejected line (`E`)
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  asynchronous, active-high reset
- `rx_data`  in  8  received byte from `uart_rx`
- `rx_d_val`  in  1  one-cycle strobe, `rx_data` valid
- `tx_done`  in  1  one-cycle strobe from `uart_tx`, previous byte finished
- `disp_data`  out  W  committed value for the display
- `disp_upd`  out  1  one-cycle pulse when `disp_data` changes
- `tx_data`  out  8  response byte; held stable from `tx_start` until `tx_done`
- `tx_start`  out  1  one-cycle request to `uart_tx`
- `err`  out  1  one-cycle pulse on every rejected line
- `tx_ovf`  out  1  sticky; a response was dropped because the transmitter was busy

## Operation
- Character classes:
  - HEX: `0-9`, `A-F`, `a-f`
  - TERM: 0x0D, 0x0A
  - ESC: 0x1B
  - OTHER: any other byte
- Parse FSM, evaluated only on `rx_d_val`:
  - EMPTY:
    - HEX: acc <= nibble, cnt <= 1, go to ACCUM.
    - TERM: ignored, so CR LF and blank lines give no response.
    - ESC: no action.
    - OTHER: go to ERROR.
  - ACCUM:
    - HEX with cnt < NUM_DIGITS: acc <= {acc[W-5:0], nibble}, cnt++.
    - HEX with cnt == NUM_DIGITS: go to ERROR (overlong).
    - TERM: commit, go to EMPTY.
    - ESC: clear acc/cnt, go to EMPTY, no response.
    - OTHER: go to ERROR.
  - ERROR:
    - TERM: reject, go to EMPTY.
    - ESC: go to EMPTY silently.
    - HEX/OTHER: discarded.
- Commit:
  - `disp_data` <= acc, right-aligned and zero-extended. `1F` gives 0x001F.
  - Pulse `disp_upd`.
  - Request response `ACK_OK`.
- Reject:
  - Pulse `err`.
  - Request response `ACK_ERR`.
  - `disp_data` is unchanged.
- TX FSM:
  - TX_IDLE: a response request drives `tx_data` and pulses `tx_start`, then goes to TX_WAIT.
  - TX_WAIT: `tx_done` returns to TX_IDLE.
  - A request arriving in TX_WAIT is dropped and sets `tx_ovf`. The display commit still happens.
- `tx_done` received in TX_IDLE is ignored.

## Timing
- Reset values:
  - `disp_data`=0, `disp_upd`=0, `tx_data`=8'h00, `tx_start`=0, `err`=0, `tx_ovf`=0.
  - Parse FSM = EMPTY, cnt=0, acc=0, TX FSM = TX_IDLE.
- Latency: `rx_d_val` in cycle N gives `disp_upd`, `err` and `tx_start` registered in cycle N+1.
- Back-to-back `rx_d_val` on consecutive cycles must be accepted. The parser has no stall and no back-pressure to `uart_rx`.
- Simultaneous `tx_done` and response request in the same cycle: the request is dropped and sets `tx_ovf`. The TX FSM is still in TX_WAIT during that evaluation. The FSM then returns to TX_IDLE.
- Reset asserted mid-line: the partial accumulator is lost and no response is sent. Reset asserted mid-TX: `tx_start` stays low and the byte already handed to `uart_tx` is not tracked.
- `tx_ovf` clears only on `rst`.

## Structure
- Shared package `uart_pkg` holds:
  - ASCII constants CHAR_CR, CHAR_LF, CHAR_ESC.
  - Parse state encoding (EMPTY/ACCUM/ERROR) and TX state encoding (TX_IDLE/TX_WAIT).
  - Default ACK_OK/ACK_ERR values.
- One sub-module, `ascii_hex_decode`: combinational, byte in, {is_hex, is_term, is_esc, nibble[3:0]} out.
- Two FSMs and the accumulator live in `uart_cmd_parser`.

## Test plan
- Send `1`,`2`,`A`,`f`,0x0D:
  - `disp_data`=0x12AF and `disp_upd` pulse 1 cycle after the CR.
  - `tx_start` with `tx_data`=0x4B.
- Send `7`,0x0D,0x0A: `disp_data`=0x0007. Exactly one `K`; the LF produces nothing.
- Send `12345`,0x0D and then `G`,0x0D: each gives an `err` pulse and `E`. `disp_data` is unchanged.
- Send `AB`,0x1B,0x0D: no `disp_upd`, no `tx_start`, no `err`.
- Send `1`,CR,`2`,CR without `tx_done`:
  - `disp_data`=0x0002 after the second CR.
  - One `tx_start` only, and `tx_ovf`=1.
  - Also drive `tx_done` in the same cycle as a later request: that request is dropped and sets `tx_ovf`, then the FSM returns to TX_IDLE.
- Assert `rst` after `3`,`4`:
  - All outputs go to their reset values.
  - A following `5`,CR gives `disp_data`=0x0005.
